// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared FSM encoding and slice width for the sequential adder
package seq_add_pkg;

  localparam int SLICE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/add2_slice.sv
// rtl/add2_slice.sv - combinational 2-bit adder slice with carry-in and carry-out
module add2_slice
  import seq_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign s     = total[SLICE_W-1:0];
  assign cout  = total[SLICE_W];

endmodule

// File: rtl/seq_add_ctrl.sv
// rtl/seq_add_ctrl.sv - WIDTH-bit adder built from one time-shared 2-bit slice, LSB first
// Optional subtract mode and sub port enabled by defining SEQ_ADD_SUB_EN.
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / SLICE_W;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int BW    = IDXW + 1;

  logic [1:0]         state;
  logic [IDXW-1:0]    idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   b_eff;
  logic               carry_init;
  logic [BW-1:0]      base;
  logic               last;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_c;

  // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in at accept time.
`ifdef SEQ_ADD_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_eff      = b;
  assign carry_init = 1'b0;
`endif

  assign base = {idx, 1'b0};
  assign last = (idx == IDXW'(STEPS - 1));
  assign sl_a = a_q[base +: SLICE_W];
  assign sl_b = b_q[base +: SLICE_W];

  add2_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b_eff;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            idx   <= '0;
            carry <= carry_init;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[base +: SLICE_W] <= sl_s;
          carry                <= sl_c;
          idx                  <= idx + IDXW'(1);
          if (last) begin
            // Overflow: operands agree in sign but the result's sign differs.
            cout  <= sl_c;
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
            idx   <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// tb/tb_seq_add_ctrl.sv - scoreboard bench for seq_add_ctrl at WIDTH=8
module tb_seq_add_ctrl;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub_i;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;
  exp_t q[$];
  exp_t mon_e;

  seq_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SEQ_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 sum=%0h", sum);
      end else begin
        mon_e = q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, mon_e.s});
        chk("cout", {31'd0, cout}, {31'd0, mon_e.c});
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.o});
        chk("latency", cyc - mon_e.acc, 4);
      end
    end
  end

  task automatic push_exp(input logic [7:0] es, input logic ec, input logic eo, input int acc);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo; e.acc = acc;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  // Caller positions at a negedge (or low phase); accept happens on the next posedge.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                        input logic [7:0] es, input logic ec, input logic eo);
    int cnt;
    bit seen;
    a = va; b = vb; sub_i = vs; start = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", {31'd0, busy}, 1);
    push_exp(es, ec, eo, cyc);
    start = 1'b0;
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) cnt++;
    end
    chk("done_seen", {31'd0, seen}, 1);
    chk("busy_cycles", cnt, 4);
    @(negedge clk);
    chk("sum_hold", {24'd0, sum}, {24'd0, es});
  endtask

  initial begin
    int base_cyc;
    int dc0;
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_i = 1'b0;
    #1;
    chk("reset_outputs", {20'd0, busy, done, cout, ovf, sum}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk); run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    @(negedge clk); run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk); run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk); run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef SEQ_ADD_SUB_EN
    @(negedge clk); run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk); run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    sub_i = 1'b0;
`endif

    // A start pulsed mid-RUN must not disturb the operation in flight.
    dc0 = done_cnt;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    push_exp(8'h96, 1'b0, 1'b1, cyc);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(20);
    repeat (8) @(negedge clk);
    chk("midrun_done_count", done_cnt - dc0, 1);

    // Reset after two RUN edges: outputs clear at once and no done follows.
    dc0 = done_cnt;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {20'd0, busy, done, cout, ovf, sum}, 0);
    repeat (6) @(negedge clk);
    chk("reset_no_done", done_cnt - dc0, 0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Start held high for 20 edges: accepts every 6 cycles, one done each.
    dc0 = done_cnt;
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    base_cyc = cyc;
    for (int k = 0; k < 4; k++) push_exp(8'h46, 1'b0, 1'b0, base_cyc + 6 * k);
    repeat (19) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(30);
    repeat (8) @(negedge clk);
    chk("held_done_count", done_cnt - dc0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
